// File: rtl/shift_arb_ctrl.sv
// shift_arb_ctrl: two-requester arbiter in front of one shared 32-bit right
// shifter. SLL and SRA are folded onto the right shifter by bit-reversing
// (SLL) or inverting (negative SRA) the operand before and after the shift.
// Optional feature macro: SHIFT_ARB_RR_EN selects round-robin arbitration;
// when undefined, req0 has fixed priority over req1.

// Plain logical right shifter shared by all operations.
module shift_right_32b (
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  output logic [31:0] out
);
  assign out = in >> shamt;
endmodule

module shift_arb_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic [1:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data_i,
  input  logic [4:0]  req1_shamt_i,
  input  logic [1:0]  req1_op_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_id_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  state_t      state_q;
  state_t      state_d;
  logic        grant_id;
  logic        accept;

  logic [31:0] data_p0;
  logic [4:0]  shamt_p0;
  logic [1:0]  op_p0;
  logic        id_p0;

  logic        is_sll;
  logic        is_neg_sra;
  logic [31:0] shf_in;
  logic [31:0] shf_out;
  logic [31:0] result;

`ifdef SHIFT_ARB_RR_EN
  logic        rr_ptr_q;
`endif

  function automatic logic [31:0] bit_rev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

  // Arbitration: pick the winner among valid requesters.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef SHIFT_ARB_RR_EN
      grant_id = rr_ptr_q;
`else
      grant_id = 1'b0;
`endif
    end else if (req1_valid_i) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated by reset so nothing is granted while reset is held.
  assign accept = (state_q == IDLE) && rst_ni && (req0_valid_i || req1_valid_i);

  // State register and arbitration pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
`ifdef SHIFT_ARB_RR_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SHIFT_ARB_RR_EN
      if (accept) rr_ptr_q <= ~grant_id;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    req0_ready_o = accept && !grant_id;
    req1_ready_o = accept && grant_id;
    busy_o       = (state_q != IDLE);
    rsp_valid_o  = (state_q == RESP);
  end

  // Stage p0: capture the granted request so later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_p0  <= grant_id ? req1_data_i  : req0_data_i;
      shamt_p0 <= grant_id ? req1_shamt_i : req0_shamt_i;
      op_p0    <= grant_id ? req1_op_i    : req0_op_i;
      id_p0    <= grant_id;
    end
  end

  // Fold SLL and negative SRA onto the right shifter and undo afterwards.
  always_comb begin
    is_sll     = (op_p0 == OP_SLL);
    is_neg_sra = (op_p0 == OP_SRA) && data_p0[31];
    if (is_sll)          shf_in = bit_rev(data_p0);
    else if (is_neg_sra) shf_in = ~data_p0;
    else                 shf_in = data_p0;
    if (is_sll)          result = bit_rev(shf_out);
    else if (is_neg_sra) result = ~shf_out;
    else                 result = shf_out;
  end

  shift_right_32b u_shifter (
    .in    (shf_in),
    .shamt (shamt_p0),
    .out   (shf_out)
  );

  // Stage p1: register the result in EXEC; held through RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_data_o <= 32'd0;
      rsp_id_o   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data_o <= result;
      rsp_id_o   <= id_p0;
    end
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Scoreboard bench for shift_arb_ctrl. Drivers push expected responses on
// each handshake; a negedge monitor pops and compares, and also checks
// latency, hold-under-backpressure and grant legality.
module tb_shift_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_data_i, req1_data_i;
  logic [4:0]  req0_shamt_i, req1_shamt_i;
  logic [1:0]  req0_op_i, req1_op_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_id_o;
  logic        busy_o;

  always #5 clk = ~clk;

  shift_arb_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_data_i  (req0_data_i),
    .req0_shamt_i (req0_shamt_i),
    .req0_op_i    (req0_op_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_data_i  (req1_data_i),
    .req1_shamt_i (req1_shamt_i),
    .req1_op_i    (req1_op_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_id_o     (rsp_id_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_id = 1'b0;
  logic        rr_model = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b10:   return d << s;
      2'b01:   return 32'(sd >>> s);
      default: return d >> s;
    endcase
  endfunction

  // Response monitor and protocol checker.
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb.delete();
      rr_model   = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (rsp_valid_o && !prev_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
        else chk("rsp_latency", 32'(cyc - sb[0].acc), 32'd2);
      end
      if (rsp_valid_o && prev_valid && !prev_ready) begin
        chk("hold_data", rsp_data_o, prev_data);
        chk("hold_id", 32'(rsp_id_o), 32'(prev_id));
      end
      if (rsp_valid_o && rsp_ready_i && sb.size() > 0) begin
        chk("rsp_data", rsp_data_o, sb[0].data);
        chk("rsp_id", 32'(rsp_id_o), 32'(sb[0].id));
        void'(sb.pop_front());
      end
      if (req0_ready_o || req1_ready_o) begin
        chk("grant_legal", 32'({req0_ready_o & req1_ready_o, req0_ready_o & ~req0_valid_i,
                                req1_ready_o & ~req1_valid_i, busy_o}), 32'd0);
        if (req0_valid_i && req1_valid_i) begin
`ifdef SHIFT_ARB_RR_EN
          chk("arb_winner", 32'(req1_ready_o), 32'(rr_model));
`else
          chk("arb_winner", 32'(req1_ready_o), 32'd0);
`endif
        end
        if (req0_ready_o && req0_valid_i) rr_model = 1'b1;
        else if (req1_ready_o && req1_valid_i) rr_model = 1'b0;
      end
      prev_valid = rsp_valid_o;
      prev_ready = rsp_ready_i;
      prev_data  = rsp_data_o;
      prev_id    = rsp_id_o;
    end
  end

  // Issue one request on a port; called and returns at posedge+1.
  task automatic issue(input logic port, input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] op, input logic [31:0] exp);
    logic done;
    done = 1'b0;
    if (port) begin
      req1_data_i = d; req1_shamt_i = s; req1_op_i = op; req1_valid_i = 1'b1;
    end else begin
      req0_data_i = d; req0_shamt_i = s; req0_op_i = op; req0_valid_i = 1'b1;
    end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (port ? req1_ready_o : req0_ready_o) begin
        sb.push_back('{id: port, data: exp, acc: cyc});
        done = 1'b1;
      end
    end
    chk("handshake_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    if (port) req1_valid_i = 1'b0;
    else      req0_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {25'd0, rsp_valid_o, |rsp_data_o, rsp_id_o, busy_o, req0_ready_o,
               req1_ready_o, 1'b0}, 32'd0);
  endtask

  logic [1:0] gseq [4];
  logic [4:0] rs;
  logic [31:0] rd;
  logic [1:0] rop;
  logic        rport;
  logic        gid;
  logic        got;

  initial begin
    rst_ni = 1'b0; rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b0;
    req0_data_i = 32'd0; req0_shamt_i = 5'd0; req0_op_i = 2'b00;
    req1_data_i = 32'd0; req1_shamt_i = 5'd0; req1_op_i = 2'b00;

    // Reset state, with a pending request that must not be granted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_ni = 1'b1; req0_valid_i = 1'b0;

    // Directed single operations.
    issue(1'b0, 32'hF000_0000, 5'd4,  2'b00, 32'h0F00_0000);
    issue(1'b1, 32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF);
    issue(1'b1, 32'h0000_0001, 5'd31, 2'b10, 32'h8000_0000);
    issue(1'b0, 32'h8000_0000, 5'd1,  2'b11, 32'h4000_0000);
    issue(1'b1, 32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
    issue(1'b0, 32'h7000_0000, 5'd4,  2'b01, 32'h0700_0000);
    drain();

    // Contention: both requesters valid for four grants.
`ifdef SHIFT_ARB_RR_EN
    gseq = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    gseq = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    req0_data_i = 32'h0000_00F0; req0_shamt_i = 5'd4; req0_op_i = 2'b00;
    req1_data_i = 32'h0000_0001; req1_shamt_i = 5'd4; req1_op_i = 2'b10;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0; gid = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (req0_ready_o || req1_ready_o) begin
          gid = req1_ready_o;
          sb.push_back('{id: gid, data: gid ? 32'h0000_0010 : 32'h0000_000F, acc: cyc});
          got = 1'b1;
        end
      end
      chk("contention_grant", {30'd0, got, gid}, {30'd0, 1'b1, gseq[g][0]});
      @(posedge clk); #1;
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    drain();

    // Backpressure with changing request inputs.
    rsp_ready_i = 1'b0;
    issue(1'b0, 32'h1234_5678, 5'd8, 2'b00, 32'h0012_3456);
    req0_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_ready_low", {30'd0, req0_ready_o, req1_ready_o}, 32'd0);
      @(posedge clk); #1;
      req0_data_i = 32'(i + 1) * 32'h1111_1111;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_ready", {30'd0, busy_o, req0_ready_o}, 32'd1);
    if (req0_ready_o)
      sb.push_back('{id: 1'b0, data: ref_shift(req0_data_i, 5'd8, 2'b00), acc: cyc});
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    drain();

    // Reset in EXEC discards the operation.
    issue(1'b0, 32'hA5A5_A5A5, 5'd4, 2'b01, 32'hFA5A_5A5A);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_mid_exec");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp_valid_o), 32'd0);
    end
    @(posedge clk); #1;
    issue(1'b1, 32'hA5A5_A5A5, 5'd4, 2'b01, 32'hFA5A_5A5A);
    drain();

    // Random operations on both ports, with forced shamt 0 and 31.
    for (int i = 0; i < 1000; i++) begin
      rport = 1'($urandom_range(0, 1));
      rd    = $urandom;
      rop   = 2'($urandom_range(0, 3));
      if (i % 20 == 0)      rs = 5'd0;
      else if (i % 20 == 1) rs = 5'd31;
      else                  rs = 5'($urandom_range(0, 31));
      issue(rport, rd, rs, rop, ref_shift(rd, rs, rop));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the shift amount at 5 bits.
REQ-002 clk_i  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 req0_valid_i / req1_valid_i  input  1  requester 0/1 has a shift pending.
REQ-005 req0_ready_o / req1_ready_o  output  1  grant to requester 0/1; handshake completes when valid and ready are both 1.
REQ-006 req0_data_i / req1_data_i  input  32  operand.
REQ-007 req0_shamt_i / req1_shamt_i  input  5  shift amount, 0..31.
REQ-008 req0_op_i / req1_op_i  input  2  shift operation: 00 SRL, 01 SRA, 10 SLL, 11 treated as SRL.
REQ-009 rsp_valid_o  output  1  result available.
REQ-010 rsp_ready_i  input  1  consumer accepts the result.
REQ-011 rsp_data_o  output  32  shift result.
REQ-012 rsp_id_o  output  1  index of the requester that owns the result.
REQ-013 busy_o  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL contain exactly one instance of shift_right_32b (in, shamt, out), shared by both requesters.
REQ-015 FSM SHALL have 3 states: IDLE, EXEC and RESP.
- IDLE -> EXEC when a request is accepted.
- EXEC -> RESP unconditionally.
- RESP -> IDLE when rsp_ready_i is 1.
REQ-016 In IDLE, at most one ready output SHALL be 1, and only for a requester whose valid is 1; ready SHALL be 0 in EXEC and RESP.
REQ-017 On acceptance, data, shamt, op and id SHALL be latched; later changes on the request inputs SHALL NOT affect the result.
REQ-018 In EXEC, the shifter input SHALL be pre-processed as follows:
- SLL: bit-reversed operand.
- SRA with operand bit 31 set: bitwise-inverted operand.
- All other cases: operand unchanged.
REQ-019 In EXEC, the shifter output SHALL be post-processed with the matching inverse (bit-reverse for SLL, invert for negative SRA) and registered into rsp_data_o.
REQ-020 Results SHALL equal the RV32I SLL, SRL and SRA semantics for every shamt 0..31; shamt 0 SHALL return the operand unchanged.
REQ-021 rsp_valid_o SHALL be 1 exactly in RESP, rising 2 cycles after the acceptance edge.
REQ-022 rsp_data_o and rsp_id_o SHALL be held stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-023 After rsp_ready_i=1 in RESP, the block SHALL be in IDLE on the next cycle; minimum spacing between acceptances is 3 cycles.
REQ-024 Requests arriving in EXEC or RESP SHALL wait, with ready=0, and SHALL NOT be dropped.

Reset
REQ-025 When rst_ni=0 at a rising edge, the following SHALL hold from that edge:
- state = IDLE;
- rsp_valid_o, rsp_data_o, rsp_id_o, busy_o and both ready outputs = 0;
- round-robin pointer = "req0 next".
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid_o pulse SHALL follow.

Configuration
REQ-027 With SHIFT_ARB_RR_EN defined, arbitration SHALL be round-robin:
- when both requesters are valid, the one not granted last SHALL win;
- the pointer SHALL update only on acceptance.
REQ-028 Without SHIFT_ARB_RR_EN, arbitration SHALL be fixed priority, with req0 always winning over req1.

Verification
REQ-029 Single SRL: req0 data 0xF000_0000, shamt 4, op 00 -> rsp_valid_o 2 cycles after acceptance, rsp_data_o 0x0F00_0000, rsp_id_o 0.
REQ-030 Single SRA and SLL: req1 data 0x8000_0000, shamt 31, op 01 -> 0xFFFF_FFFF, id 1; then req1 data 0x0000_0001, shamt 31, op 10 -> 0x8000_0000.
REQ-031 Contention: both requesters valid for 4 back-to-back requests.
- With SHIFT_ARB_RR_EN: grants alternate 0,1,0,1.
- Without it: four grants to req0, req1 starved while req0 stays valid.
REQ-032 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP, while changing req0_data_i each cycle.
- rsp_data_o and rsp_id_o stay stable; ready outputs stay 0.
- IDLE is reached the cycle after rsp_ready_i=1.
REQ-033 Reset mid-operation: assert rst_ni=0 for one cycle in EXEC -> all outputs 0 next cycle, no response, and the next request is served normally.
REQ-034 Random: 1000 random operand/shamt/op triples on both ports, each result checked against the reference SLL/SRL/SRA model, with shamt 0 and 31 forced at least 10 times each.
